// File: rtl/led_seq_player_if.sv
// led_seq_player_if: host write, playback control, status and RAM port bundle
interface led_seq_player_if #(parameter int AW = 3, parameter int LED_W = 6);
  logic i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic i_start;
  logic i_stop;
  logic o_busy;
  logic [LED_W-1:0] o_led;
  logic o_step;
  logic [AW-1:0] o_cur_addr;
  logic [AW-1:0] o_ram_ad;
  logic [31:0] o_ram_di;
  logic o_ram_wre;
  logic [31:0] i_ram_dout;
  modport master(
    output i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop, i_ram_dout,
    input o_busy, o_led, o_step, o_cur_addr, o_ram_ad, o_ram_di, o_ram_wre
  );
  modport slave(
    input i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop, i_ram_dout,
    output o_busy, o_led, o_step, o_cur_addr, o_ram_ad, o_ram_di, o_ram_wre
  );
endinterface

// File: rtl/led_seq_player.sv
// led_seq_player: plays LED pattern/dwell words from a shared 8x32 RAM port, host writes take priority
module led_seq_player #(
  parameter int AW = 3,
  parameter int LED_W = 6,
  parameter int DWELL_W = 24
) (
  input logic clk,
  input logic rst,
  led_seq_player_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic r_last;
  logic [LED_W-1:0] r_led;
  logic r_step;
  logic [AW-1:0] r_addr;
  logic [DWELL_W-1:0] w_dwell;
  assign w_dwell = bus.i_ram_dout[LED_W +: DWELL_W];
  assign bus.o_ram_wre = bus.i_wr_en;
  assign bus.o_ram_di = bus.i_wr_data;
  assign bus.o_ram_ad = bus.i_wr_en ? bus.i_wr_addr : r_addr;
  assign bus.o_busy = r_state != IDLE;
  assign bus.o_led = r_led;
  assign bus.o_step = r_step;
  assign bus.o_cur_addr = r_addr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_last <= 1'b0;
      r_led <= '0;
      r_step <= 1'b0;
      r_addr <= '0;
    end else begin
      r_step <= 1'b0;
      if (bus.i_stop)
        r_state <= IDLE;
      else
        case (r_state)
          IDLE:
            if (bus.i_start) begin
              r_addr <= '0;
              r_state <= FETCH;
            end
          FETCH:
            if (!bus.i_wr_en) begin
              r_led <= bus.i_ram_dout[LED_W-1:0];
              r_cnt <= (w_dwell == '0) ? DWELL_W'(1) : w_dwell;
              r_last <= bus.i_ram_dout[31];
              r_step <= 1'b1;
              r_state <= HOLD;
            end
          HOLD:
            if (r_cnt == DWELL_W'(1)) begin
              r_addr <= r_last ? '0 : r_addr + AW'(1);
              r_state <= FETCH;
            end else
              r_cnt <= r_cnt - DWELL_W'(1);
          default: r_state <= IDLE;
        endcase
    end
endmodule

// File: doc/led_seq_player.md
Name: led_seq_player

Overview:
- Sequencer that owns the single port of the 8x32 distributed-RAM pattern store and plays it back onto the board LEDs.
- Each RAM word holds an LED pattern, a dwell time and a last flag.
- The host loads the words through the write port; the player reads them back in order, holding each pattern for its dwell.
- Host writes share the RAM port and take priority over playback reads.

Parameters:
- AW, 3, RAM address width (8 entries).
- LED_W, 6, LED output width; word bits [LED_W-1:0].
- DWELL_W, 24, dwell field width; word bits [29:6].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  host write strobe, one word per cycle.
- wr_addr  in  AW  host write address.
- wr_data  in  32  host write word.
- start  in  1  one-cycle pulse, begin playback at entry 0.
- stop  in  1  one-cycle pulse, halt playback.
- busy  out  1  playback running.
- led  out  LED_W  registered LED pattern.
- step  out  1  one-cycle pulse when led takes a new entry.
- cur_addr  out  AW  entry currently displayed or being fetched.
- ram_ad  out  AW  RAM address.
- ram_di  out  32  RAM write data.
- ram_wre  out  1  RAM write enable.
- ram_dout  in  32  RAM read data; asynchronous read, valid in the same cycle as ram_ad.

Behaviour:
- Word format: bit 31 = last; bit 30 reserved (written as is, ignored on read); bits [29:6] = dwell in clk cycles; bits [5:0] = led pattern.
- RAM port mux (combinational):
  - ram_wre = wr_en.
  - ram_di = wr_data.
  - ram_ad = wr_en ? wr_addr : cur_addr.
  - A write on any cycle is always committed at that clk edge.
- Reset values: busy=0, led=0, step=0, cur_addr=0, dwell counter=0, state=IDLE.
- Reset is honoured mid-playback; writes in flight during reset are not guaranteed.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - led holds its last value.
  - start=1 with stop=0 -> cur_addr<=0, go to FETCH.
- FETCH:
  - If wr_en=1, the read is blocked: stay in FETCH, no other change.
  - Else capture ram_dout: led<=dout[5:0]; cnt<=dwell (dwell 0 loads 1); last_q<=dout[31]; step=1 next cycle; go to HOLD.
- HOLD:
  - If cnt==1: cur_addr<=last_q ? 0 : cur_addr+1 (mod 8; entry 7 wraps to 0 even if last=0); go to FETCH.
  - Else cnt<=cnt-1.
- Timing: an unblocked entry shows for exactly dwell+1 cycles (dwell HOLD cycles plus 1 FETCH cycle). Each blocking write adds 1 cycle.
- busy = (state != IDLE), registered with the state.
- step: registered single-cycle pulse, asserted in the first cycle the new led value is visible.
- stop:
  - Any state -> IDLE on the next edge; led keeps its value; no step.
  - stop and start in the same cycle -> stop wins.
- start while busy is ignored; playback does not restart.
- Host writes during playback are legal. A rewritten entry takes effect the next time it is fetched; the currently displayed led is unaffected.
- No combinational path from start/stop to led or busy.

Test Plan:
- Reset -> led=0, busy=0, step=0, ram_wre=0. Assert rst mid-HOLD -> all outputs return to reset values immediately (asynchronous).
- Load entry 0 = 0x0000_00C5 (dwell 3, led 0x05) and entry 1 = 0x8000_010A (last, dwell 4, led 0x0A); pulse start -> led 0x05 for 4 cycles, then 0x0A for 5 cycles, then 0x05 again. One step pulse per change; cur_addr sequence 0,1,0.
- All 8 entries dwell 1, none last -> cur_addr runs 0..7 then 0; each pattern shows 2 cycles.
- Entry dwell=0 -> behaves as dwell 1 (2 cycles per pattern, no lockup).
- Hold wr_en high for 3 cycles while the player is in FETCH -> ram_ad follows wr_addr, fetch is delayed exactly 3 cycles, and the written data lands in the RAM.
- stop during HOLD -> busy=0 next cycle, led frozen. stop+start same cycle -> stays IDLE. start while busy -> sequence continues uninterrupted.
